i2s_rx_sample_packer: RTL and testbench
=======================================

Name: i2s_rx_sample_packer

Overview:
- Sits directly downstream of the I2S/DSP RX channel.
- Consumes the channel's 32-bit per-word valid/ready stream and packs 8-bit or 16-bit samples into 32-bit words. 24/32-bit samples pass through unpacked.
- Buffers the result in a small FIFO that feeds the uDMA RX channel.
- Cuts uDMA bandwidth for narrow samples and absorbs short stalls that would otherwise drop audio words.

Parameters:
FIFO_DEPTH, 4, number of 32-bit entries in output FIFO (power of 2, >=2)

Ports:
sck_i  input  1  clock, same domain as the RX channel
rst_i  input  1  asynchronous active-high reset
in_data_i  input  32  sample word from RX channel, right-aligned
in_valid_i  input  1  sample word valid
in_ready_o  output  1  packer can accept a sample this cycle
out_data_o  output  32  packed word to uDMA (FIFO head)
out_valid_o  output  1  FIFO non-empty
out_ready_i  input  1  uDMA accepts head word
err_o  output  1  one-cycle pulse: sample offered while in_ready_o low (sample lost)
cfg_en_i  input  1  packer enable
cfg_num_bits_i  input  5  sample width minus 1 (7, 15, 23, 31), same encoding as the RX channel
cfg_pack_en_i  input  1  1 = pack 8/16-bit samples; 0 = one sample per word
cfg_sign_ext_i  input  1  1 = sign-extend samples narrower than 32 bits in unpacked output
busy_o  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_i=1) values:
  - State IDLE, lane counter 0, FIFO empty, pack register 0.
  - out_valid_o=0, out_data_o=0, in_ready_o=0, err_o=0, busy_o=0.
- The mid-operation reset discards all buffered data immediately.
- Configuration is latched on the IDLE->PACK transition. Changes while in PACK or FLUSH are ignored until the next IDLE.
- Any cfg_num_bits_i other than 7/15/23/31 is treated as 31.
- Lanes per word N, from the latched config:
  - N=4 for 8-bit with pack on.
  - N=2 for 16-bit with pack on.
  - N=1 otherwise.
- States:
  - IDLE: in_ready_o=0. If cfg_en_i=1, go to PACK next cycle. The FIFO keeps draining.
  - PACK: in_ready_o = ~fifo_full (registered full flag, i.e. full at the start of the cycle). A pop in the same cycle does not raise in_ready_o.
    - Accept occurs when in_valid_i & in_ready_o.
    - On cfg_en_i=0: if lane counter = 0, go to IDLE; else go to FLUSH.
    - A sample accepted in the same cycle that cfg_en_i falls is still taken, and the lane count after that accept decides IDLE vs FLUSH.
  - FLUSH: in_ready_o=0. When FIFO is not full, push the pack register with unfilled lanes set to zero, clear the lane counter, and go to IDLE.
- Sample formation:
  - Sample = in_data_i[num_bits:0]; upper bits are discarded.
  - Packed mode: sample k of a word goes to lane k. For 8-bit, lane k = bits [8k+7:8k]; for 16-bit, lane k = bits [16k+15:16k]. The first received sample lands in the LSBs. No sign extension is applied in packed mode.
  - Unpacked mode: sample is zero-extended to 32 bits, or sign-extended from bit num_bits when cfg_sign_ext_i=1.
- Push rules:
  - When an accepted sample fills lane N-1, the completed word is pushed into the FIFO in the same cycle and the lane counter wraps to 0.
  - The pack register holds lanes 0..N-2.
- Latency: a word completed at cycle t appears on out_data_o with out_valid_o=1 at cycle t+1 if the FIFO was empty.
- FIFO:
  - First-word fall-through.
  - Pop occurs when out_valid_o & out_ready_i.
  - Simultaneous push and pop is allowed at any occupancy when not full.
  - When empty, out_data_o holds the last popped value.
- err_o: asserted for exactly one cycle when state=PACK, in_valid_i=1 and in_ready_o=0. The sample is dropped and the lane counter is unchanged. This covers the upstream channel not holding data.
- in_valid_i is ignored in IDLE and FLUSH without error.

Test Plan:
- Packed 8-bit: cfg_num_bits_i=7, pack=1, in_data_i = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready_i=1 -> a single word 0x44332211, out_valid_o high one cycle after the 4th accept, err_o=0.
- Packed 16-bit with flush: samples 0x0000ABCD, 0x00001234, 0x00005678, then cfg_en_i=0 -> words 0x1234ABCD then 0x00005678 (FLUSH); state returns to IDLE; busy_o falls after the last pop.
- Unpacked 24-bit sign extension: cfg_num_bits_i=23, sign_ext=1, in_data_i=0xFF800001 -> out_data_o=0xFF800001. With in_data_i=0x00400000 -> 0x00400000. With sign_ext=0 and input 0x00800001 -> 0x00800001.
- Backpressure/overflow: FIFO_DEPTH=4, 32-bit mode, out_ready_i=0, 6 samples offered one per cycle -> 4 accepted; in_ready_o low from the cycle after the 4th push; err_o pulses twice. Then out_ready_i=1 -> the 4 words drain in order and in_ready_o returns high.
- Simultaneous push/pop: FIFO holding 3 words, out_ready_i=1 and a continuous 32-bit input stream -> occupancy stays at 3, one word out per cycle, no err_o.
- Reset mid-word: 8-bit packed, 2 samples accepted, rst_i pulsed -> out_valid_o=0, busy_o=0. After re-enable, the next 4 samples form a clean word with no residue from before reset.

Source files
------------

// File: rtl/i2s_rx_sample_packer.sv
// Packs 8/16-bit I2S RX samples into 32-bit words (24/32-bit pass through) and
// buffers them in a first-word fall-through FIFO ahead of the uDMA RX channel.
module i2s_rx_sample_packer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        sck_i,
   input  logic        rst_i,
   input  logic [31:0] in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [31:0] out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        err_o,
   input  logic        cfg_en_i,
   input  logic [4:0]  cfg_num_bits_i,
   input  logic        cfg_pack_en_i,
   input  logic        cfg_sign_ext_i,
   output logic        busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

   state_t        state_q;
   logic [4:0]    num_bits_q;
   logic          sign_ext_q;
   logic [1:0]    lane_max_q;
   logic [1:0]    lane_q;
   logic [1:0]    lane_next;
   logic [31:0]   pack_q;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [31:0]   last_q;

   logic          full;
   logic          empty;
   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   sample;
   logic [31:0]   placed;
   logic [31:0]   push_data;
   logic [4:0]    nb_in;

   function automatic logic [4:0] norm_bits(input logic [4:0] nb);
      case (nb)
         5'd7, 5'd15, 5'd23: return nb;
         default:            return 5'd31;
      endcase
   endfunction

   // Keep bits [nb:0]; optionally replicate bit nb into the discarded upper bits.
   function automatic logic [31:0] extend_sample(input logic [31:0] d, input logic [4:0] nb,
                                                 input logic sx);
      logic [4:0]         sh;
      logic [31:0]        up;
      logic signed [31:0] sup;
      sh  = 5'd31 - nb;
      up  = d << sh;
      sup = signed'(up);
      if (sx) return $unsigned(sup >>> sh);
      return up >> sh;
   endfunction

   function automatic logic [31:0] lane_place(input logic [31:0] s, input logic [1:0] lane,
                                              input logic [4:0] nb);
      if (nb == 5'd7) return s << {lane, 3'b000};
      return s << {lane, 4'b0000};
   endfunction

   assign nb_in       = norm_bits(cfg_num_bits_i);
   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign in_ready_o  = (state_q == PACK) && !full;
   assign accept      = in_valid_i && in_ready_o;
   assign err_o       = (state_q == PACK) && in_valid_i && !in_ready_o;
   assign pop         = !empty && out_ready_i;
   assign out_valid_o = !empty;
   assign out_data_o  = empty ? last_q : mem[rd_ptr_q];
   assign busy_o      = (state_q != IDLE) || !empty;

   // Sign extension only exists in one-sample-per-word mode.
   assign sample = extend_sample(in_data_i, num_bits_q, sign_ext_q && (lane_max_q == 2'd0));
   assign placed = lane_place(sample, lane_q, num_bits_q);

   always_comb begin
      push      = 1'b0;
      push_data = pack_q | placed;
      lane_next = lane_q;
      if (state_q == PACK && accept) begin
         if (lane_q == lane_max_q) begin
            push      = 1'b1;
            lane_next = 2'd0;
         end else begin
            lane_next = lane_q + 2'd1;
         end
      end
      if (state_q == FLUSH && !full) begin
         push      = 1'b1;
         push_data = pack_q;
      end
   end

   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         num_bits_q <= 5'd31;
         sign_ext_q <= 1'b0;
         lane_max_q <= 2'd0;
         lane_q     <= 2'd0;
         pack_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_en_i) begin
                  state_q    <= PACK;
                  num_bits_q <= nb_in;
                  sign_ext_q <= cfg_sign_ext_i;
                  if (cfg_pack_en_i && nb_in == 5'd7)       lane_max_q <= 2'd3;
                  else if (cfg_pack_en_i && nb_in == 5'd15) lane_max_q <= 2'd1;
                  else                                      lane_max_q <= 2'd0;
               end
            end
            PACK: begin
               lane_q <= lane_next;
               if (accept) pack_q <= push ? '0 : (pack_q | placed);
               if (!cfg_en_i) state_q <= (lane_next == 2'd0) ? IDLE : FLUSH;
            end
            FLUSH: begin
               if (!full) begin
                  pack_q  <= '0;
                  lane_q  <= 2'd0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem[rd_ptr_q];
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge sck_i) begin
      if (push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// Bench for i2s_rx_sample_packer: vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_i2s_rx_sample_packer;
   localparam int DEPTH = 4;

   logic        sck = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        err;
   logic        cfg_en = 1'b0;
   logic [4:0]  cfg_nb = 5'd31;
   logic        cfg_pack = 1'b0;
   logic        cfg_sx = 1'b0;
   logic        busy;

   always #5 sck = ~sck;

   i2s_rx_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .sck_i(sck), .rst_i(rst),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .err_o(err), .cfg_en_i(cfg_en), .cfg_num_bits_i(cfg_nb),
      .cfg_pack_en_i(cfg_pack), .cfg_sign_ext_i(cfg_sx), .busy_o(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // ---------------- reference model: phases, sample queue, FIFO queue ----------------
   int          m_phase;   // 0 idle, 1 packing, 2 flushing
   int          m_n;
   int          m_nb;
   bit          m_sx;
   bit [31:0]   m_fifo[$];
   bit [31:0]   m_part[$];
   bit [31:0]   m_last;

   function automatic void model_reset();
      m_phase = 0; m_n = 1; m_nb = 31; m_sx = 0; m_last = 0;
      m_fifo.delete();
      m_part.delete();
   endfunction

   function automatic bit [31:0] build_word();
      bit [31:0] w = 0;
      for (int k = 0; k < m_part.size(); k++) w |= m_part[k] << (k * (m_nb + 1));
      return w;
   endfunction

   task automatic model_cycle();
      bit        p_rdy, p_err, p_ovld, p_busy;
      bit [31:0] p_odata, s, mask;
      int        start_size;
      p_rdy   = (m_phase == 1) && (m_fifo.size() < DEPTH);
      p_err   = (m_phase == 1) && in_valid && !p_rdy;
      p_ovld  = (m_fifo.size() > 0);
      p_odata = p_ovld ? m_fifo[0] : m_last;
      p_busy  = (m_phase != 0) || p_ovld;
      chk1("in_ready", in_ready, p_rdy);
      chk1("err", err, p_err);
      chk1("out_valid", out_valid, p_ovld);
      chk("out_data", out_data, p_odata);
      chk1("busy", busy, p_busy);
      if (rst) begin
         model_reset();
         return;
      end
      start_size = m_fifo.size();
      if (p_ovld && out_ready) m_last = m_fifo.pop_front();
      case (m_phase)
         0: if (cfg_en) begin
            m_nb = (cfg_nb == 7 || cfg_nb == 15 || cfg_nb == 23) ? int'(cfg_nb) : 31;
            m_sx = cfg_sx;
            m_n  = (cfg_pack && m_nb == 7) ? 4 : (cfg_pack && m_nb == 15) ? 2 : 1;
            m_phase = 1;
         end
         1: begin
            if (p_rdy && in_valid) begin
               mask = (m_nb == 31) ? 32'hFFFF_FFFF : ((32'd1 << (m_nb + 1)) - 32'd1);
               s = in_data & mask;
               if (m_n == 1) begin
                  if (m_sx && s[m_nb]) s |= ~mask;
                  m_fifo.push_back(s);
               end else begin
                  m_part.push_back(s);
                  if (m_part.size() == m_n) begin
                     m_fifo.push_back(build_word());
                     m_part.delete();
                  end
               end
            end
            if (!cfg_en) m_phase = (m_part.size() == 0) ? 0 : 2;
         end
         default: if (start_size < DEPTH) begin
            m_fifo.push_back(build_word());
            m_part.delete();
            m_phase = 0;
         end
      endcase
   endtask

   task automatic drive(input bit en, input bit [4:0] nb, input bit pk, input bit sx,
                        input bit vld, input bit [31:0] d, input bit ordy);
      cfg_en = en; cfg_nb = nb; cfg_pack = pk; cfg_sx = sx;
      in_valid = vld; in_data = d; out_ready = ordy;
   endtask

   task automatic tick();
      @(negedge sck);
      model_cycle();
   endtask

   task automatic adv();
      @(posedge sck);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      chk1({tag, "_rst_valid"}, out_valid, 1'b0);
      chk1({tag, "_rst_busy"}, busy, 1'b0);
      chk1({tag, "_rst_ready"}, in_ready, 1'b0);
      chk({tag, "_rst_data"}, out_data, 32'h0);
      model_reset();
      rst = 1'b0;
   endtask

   typedef struct {
      bit en; bit [4:0] nb; bit pk; bit sx; bit vld; bit [31:0] din; bit ordy;
      bit x_rdy; bit x_ovld; bit [31:0] x_odata; bit x_err; bit x_busy;
   } vec_t;
   vec_t vt[$];

   function automatic void addv(input bit en, input bit [4:0] nb, input bit pk, input bit sx,
                                input bit vld, input bit [31:0] din, input bit ordy,
                                input bit x_rdy, input bit x_ovld, input bit [31:0] x_odata,
                                input bit x_err, input bit x_busy);
      vec_t v;
      v.en = en; v.nb = nb; v.pk = pk; v.sx = sx; v.vld = vld; v.din = din; v.ordy = ordy;
      v.x_rdy = x_rdy; v.x_ovld = x_ovld; v.x_odata = x_odata; v.x_err = x_err; v.x_busy = x_busy;
      vt.push_back(v);
   endfunction

   bit [31:0] data [8];
   int        acc, errs;
   bit [4:0]  nb_pick [6] = '{5'd7, 5'd15, 5'd23, 5'd31, 5'd5, 5'd0};

   initial begin
      model_reset();
      drive(0, 5'd31, 0, 0, 0, 32'h0, 0);
      tick();
      #2 rst = 1'b0;
      adv();

      // 8-bit packed word, 24-bit sign extension, config ignored mid-run, illegal width.
      addv(1, 7, 1, 0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0);
      addv(1, 7, 1, 0, 1, 32'hABCDEF11, 1,  1, 0, 32'h0,        0, 1);
      addv(1, 7, 1, 0, 1, 32'h22,       1,  1, 0, 32'h0,        0, 1);
      addv(1, 7, 1, 0, 1, 32'h33,       1,  1, 0, 32'h0,        0, 1);
      addv(1, 7, 1, 0, 1, 32'h44,       1,  1, 0, 32'h0,        0, 1);
      addv(1, 7, 1, 0, 0, 32'h0,        1,  1, 1, 32'h44332211, 0, 1);
      addv(0, 7, 1, 0, 0, 32'h0,        1,  1, 0, 32'h44332211, 0, 1);
      addv(0, 7, 1, 0, 0, 32'h0,        1,  0, 0, 32'h44332211, 0, 0);
      addv(1, 23, 0, 1, 0, 32'h0,       1,  0, 0, 32'h44332211, 0, 0);
      addv(1, 23, 0, 1, 1, 32'hFF800001, 1, 1, 0, 32'h44332211, 0, 1);
      addv(1, 23, 0, 1, 1, 32'h00400000, 1, 1, 1, 32'hFF800001, 0, 1);
      addv(1, 7, 1, 0, 1, 32'h12800001,  1, 1, 1, 32'h00400000, 0, 1);
      addv(0, 23, 0, 1, 0, 32'h0,       1,  1, 1, 32'hFF800001, 0, 1);
      addv(0, 23, 0, 0, 0, 32'h0,       1,  0, 0, 32'hFF800001, 0, 0);
      addv(1, 23, 0, 0, 0, 32'h0,       1,  0, 0, 32'hFF800001, 0, 0);
      addv(1, 23, 0, 0, 1, 32'h00800001, 1, 1, 0, 32'hFF800001, 0, 1);
      addv(0, 23, 0, 0, 0, 32'h0,       1,  1, 1, 32'h00800001, 0, 1);
      addv(0, 23, 0, 0, 0, 32'h0,       1,  0, 0, 32'h00800001, 0, 0);
      addv(1, 5, 1, 1, 0, 32'h0,        1,  0, 0, 32'h00800001, 0, 0);
      addv(1, 5, 1, 1, 1, 32'h87654321, 1,  1, 0, 32'h00800001, 0, 1);
      addv(0, 5, 1, 1, 0, 32'h0,        1,  1, 1, 32'h87654321, 0, 1);
      addv(0, 5, 1, 1, 1, 32'h0000DEAD, 1,  0, 0, 32'h87654321, 0, 0);
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].en, vt[i].nb, vt[i].pk, vt[i].sx, vt[i].vld, vt[i].din, vt[i].ordy);
         tick();
         chk1($sformatf("vec%0d_ready", i), in_ready, vt[i].x_rdy);
         chk1($sformatf("vec%0d_valid", i), out_valid, vt[i].x_ovld);
         chk($sformatf("vec%0d_data", i), out_data, vt[i].x_odata);
         chk1($sformatf("vec%0d_err", i), err, vt[i].x_err);
         chk1($sformatf("vec%0d_busy", i), busy, vt[i].x_busy);
         adv();
      end

      // 16-bit packing with a partial word flushed on disable.
      drive(1, 15, 1, 0, 0, 32'h0, 1);          tick(); adv();
      drive(1, 15, 1, 0, 1, 32'h0000ABCD, 1);   tick(); adv();
      drive(1, 15, 1, 0, 1, 32'h00001234, 1);   tick(); adv();
      drive(1, 15, 1, 0, 1, 32'h00005678, 1);   tick();
      chk("flush_word0", out_data, 32'h1234ABCD); chk1("flush_valid0", out_valid, 1'b1); adv();
      drive(0, 15, 1, 0, 0, 32'h0, 1);          tick();
      chk1("flush_empty", out_valid, 1'b0); adv();
      tick();
      chk1("flush_ready", in_ready, 1'b0); chk1("flush_busy", busy, 1'b1); adv();
      tick();
      chk("flush_word1", out_data, 32'h00005678); chk1("flush_valid1", out_valid, 1'b1); adv();
      tick();
      chk1("flush_idle_busy", busy, 1'b0); adv();

      // Overflow: six offers into a stalled four-entry FIFO.
      drive(1, 31, 0, 0, 0, 32'h0, 0); tick(); adv();
      acc = 0; errs = 0;
      for (int i = 0; i < 6; i++) begin
         data[i] = $urandom;
         drive(1, 31, 0, 0, 1, data[i], 0);
         tick();
         if (in_valid && in_ready) acc++;
         if (err) errs++;
         if (i == 4) chk1("ovf_ready_low", in_ready, 1'b0);
         adv();
      end
      chk("ovf_accepts", acc, 32'd4);
      chk("ovf_errs", errs, 32'd2);
      for (int k = 0; k < 4; k++) begin
         drive(1, 31, 0, 0, 0, 32'h0, 1);
         tick();
         chk1($sformatf("ovf_drain_valid%0d", k), out_valid, 1'b1);
         chk($sformatf("ovf_drain_data%0d", k), out_data, data[k]);
         if (k == 0) chk1("ovf_ready_while_full", in_ready, 1'b0);
         if (k == 1) chk1("ovf_ready_back", in_ready, 1'b1);
         adv();
      end
      drive(0, 31, 0, 0, 0, 32'h0, 1); tick(); adv();
      tick(); chk1("ovf_final_empty", out_valid, 1'b0); adv();

      // Steady push/pop with three words resident.
      drive(1, 31, 0, 0, 0, 32'h0, 0); tick(); adv();
      for (int i = 0; i < 3; i++) begin
         drive(1, 31, 0, 0, 1, $urandom, 0); tick(); adv();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 31, 0, 0, 1, $urandom, 1);
         tick();
         chk1($sformatf("pp_ready%0d", i), in_ready, 1'b1);
         chk1($sformatf("pp_err%0d", i), err, 1'b0);
         adv();
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 31, 0, 0, 0, 32'h0, 1); tick(); adv();
      end

      // Reset in the middle of a word with a completed word still queued.
      drive(1, 7, 1, 0, 0, 32'h0, 0); tick(); adv();
      for (int i = 1; i <= 6; i++) begin
         drive(1, 7, 1, 0, 1, (i <= 4) ? i : 32'hA0 + i, 0); tick(); adv();
      end
      do_reset("mid");
      drive(1, 7, 1, 0, 0, 32'h0, 1); tick(); adv();
      for (int i = 0; i < 4; i++) begin
         drive(1, 7, 1, 0, 1, 32'h55 + 32'h11 * i, 1); tick(); adv();
      end
      drive(1, 7, 1, 0, 0, 32'h0, 1); tick();
      chk("rst_clean_word", out_data, 32'h88776655);
      chk1("rst_clean_valid", out_valid, 1'b1);
      adv();
      drive(0, 7, 1, 0, 0, 32'h0, 1); tick(); adv();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) do_reset("rnd");
         drive($urandom_range(0, 15) != 0, nb_pick[$urandom_range(0, 5)], 1'($urandom),
               1'($urandom), $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
         tick();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
